// File: rtl/uart_tx_frame_arbiter_pkg.sv
// Shared types and constants for the UART transmit frame arbiter.
package uart_tx_frame_arbiter_pkg;

  // Frame sequencing states: one idle slot, then SOF, ID, payload bytes, checksum.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_ID,
    ST_PAYLOAD,
    ST_CSUM
  } state_t;

  // Default start-of-frame marker the receiver resynchronises on.
  localparam logic [7:0] DEFAULT_SOF = 8'h7E;

endpackage

// File: rtl/uart_tx_frame_arbiter_rr.sv
// Round-robin pick: first requester strictly after the pointer, wrapping.
// Purely combinational; the pointer register is kept by the frame FSM.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;
  logic          found;

  // Scan ptr+1, ptr+2, ... wrapping; the first set request wins.
  always_comb begin
    cand  = '0;
    found = 1'b0;
    idx   = '0;
    gnt   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      gnt[i] = en & found & (idx == IW'(i));
    end
  end

endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// Shares one UART TX FIFO write port among NREQ byte streams, one framed
// message (SOF, ID, payload, XOR checksum) per grant, round-robin.
module uart_tx_frame_arbiter
  import uart_tx_frame_arbiter_pkg::*;
#(
  parameter int         NREQ    = 4,
  parameter int         DBIT    = 8,
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] SOF     = DEFAULT_SOF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      s_valid,
  input  logic [NREQ-1:0]      s_last,
  input  logic [NREQ*DBIT-1:0] s_data,
  output logic [NREQ-1:0]      s_ready,
  output logic [DBIT-1:0]      w_data,
  output logic                 wr_uart,
  input  logic                 tx_full,
  output logic [NREQ-1:0]      grant,
  output logic                 busy
);

  localparam int IW = $clog2(NREQ);
  localparam int LW = $clog2(MAX_LEN + 1);

  state_t          state, state_next;
  logic [IW-1:0]   ptr, gidx, arb_idx;
  logic [NREQ-1:0] arb_gnt;
  logic [LW-1:0]   len_cnt;
  logic [DBIT-1:0] csum;
  logic [DBIT-1:0] sel_data;
  logic            sel_valid, sel_last;
  logic            any_req, xfer;

  assign any_req = |s_valid;
  assign busy    = (state != ST_IDLE);

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req (s_valid),
    .ptr (ptr),
    .en  (state == ST_IDLE),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Route the granted requester's stream onto local select signals.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx == IW'(i)) begin
        sel_data  = s_data[i*DBIT +: DBIT];
        sel_valid = s_valid[i];
        sel_last  = s_last[i];
      end
    end
  end

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and output muxes; every byte write is gated by tx_full.
  always_comb begin
    state_next = state;
    w_data     = '0;
    wr_uart    = 1'b0;
    xfer       = 1'b0;
    s_ready    = '0;
    case (state)
      ST_IDLE: begin
        if (any_req) state_next = ST_SOF;
      end
      ST_SOF: begin
        w_data  = DBIT'(SOF);
        wr_uart = !tx_full;
        if (!tx_full) state_next = ST_ID;
      end
      ST_ID: begin
        w_data  = DBIT'(gidx);
        wr_uart = !tx_full;
        if (!tx_full) state_next = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        w_data  = sel_data;
        xfer    = sel_valid & !tx_full;
        wr_uart = xfer;
        for (int i = 0; i < NREQ; i++) begin
          s_ready[i] = xfer & (gidx == IW'(i));
        end
        if (xfer && (sel_last || len_cnt == LW'(MAX_LEN - 1))) state_next = ST_CSUM;
      end
      ST_CSUM: begin
        w_data  = csum;
        wr_uart = !tx_full;
        if (!tx_full) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Grant, RR pointer, payload length and running checksum bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant   <= '0;
      gidx    <= '0;
      ptr     <= IW'(NREQ - 1);
      len_cnt <= '0;
      csum    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant   <= arb_gnt;
            gidx    <= arb_idx;
            ptr     <= arb_idx;
            csum    <= '0;
            len_cnt <= '0;
          end
        end
        ST_ID: begin
          if (wr_uart) csum <= DBIT'(gidx);
        end
        ST_PAYLOAD: begin
          if (xfer) begin
            csum    <= csum ^ sel_data;
            len_cnt <= len_cnt + 1'b1;
          end
        end
        ST_CSUM: begin
          if (wr_uart) grant <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Directed bench for uart_tx_frame_arbiter with byte-level scoreboard.
module tb_uart_tx_frame_arbiter;

  localparam int NREQ    = 4;
  localparam int DBIT    = 8;
  localparam int MAX_LEN = 4;
  localparam logic [7:0] SOF_B = 8'h7E;

  typedef struct packed {
    logic [7:0]      b;
    logic [NREQ-1:0] g;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      s_valid, s_last, s_ready, grant;
  logic [NREQ*DBIT-1:0] s_data;
  logic [DBIT-1:0]      w_data;
  logic                 wr_uart, tx_full, busy;

  logic [8:0]      src_q [NREQ][$];
  exp_t            exp_q [$];
  logic [NREQ-1:0] hs, hold;
  logic            full_cfg;
  logic [NREQ-1:0] cur_g;
  logic [7:0]      cur_csum;
  int              checks = 0;
  int              failures = 0;
  int              used;

  uart_tx_frame_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .MAX_LEN(MAX_LEN), .SOF(SOF_B)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_data  (s_data),
    .s_ready (s_ready),
    .w_data  (w_data),
    .wr_uart (wr_uart),
    .tx_full (tx_full),
    .grant   (grant),
    .busy    (busy)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic src_push(input int id, input logic [7:0] b, input logic last);
    src_q[id].push_back({last, b});
  endtask

  task automatic exp_begin(input int id);
    cur_g    = NREQ'(1) << id;
    cur_csum = 8'(id);
    exp_q.push_back({SOF_B, cur_g});
    exp_q.push_back({8'(id), cur_g});
  endtask

  task automatic exp_byte(input logic [7:0] b);
    exp_q.push_back({b, cur_g});
    cur_csum = cur_csum ^ b;
  endtask

  task automatic exp_end();
    exp_q.push_back({cur_csum, cur_g});
  endtask

  // One cycle: retire last handshake, drive at negedge, sample 1 later.
  task automatic applyStimulus();
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    hs      = '0;
    tx_full = full_cfg;
    for (int i = 0; i < NREQ; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        s_valid[i]          = 1'b1;
        s_data[i*DBIT +: DBIT] = src_q[i][0][7:0];
        s_last[i]           = src_q[i][0][8];
      end else begin
        s_valid[i]          = 1'b0;
        s_data[i*DBIT +: DBIT] = '0;
        s_last[i]           = 1'b0;
      end
    end
    #1;
    hs = s_valid & s_ready;
    if (tx_full) checkOutput("no_wr_when_full", 32'(wr_uart), 32'd0);
    if (wr_uart) begin
      checkOutput("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("w_data", 32'(w_data), 32'(e.b));
        checkOutput("grant_on_write", 32'(grant), 32'(e.g));
      end
    end
  endtask

  task automatic run_until(input int n, input int budget, input string tag, output int cyc);
    cyc = 0;
    while (exp_q.size() > n && cyc < budget) begin
      applyStimulus();
      cyc++;
    end
    checkOutput(tag, 32'(exp_q.size()), 32'(n));
  endtask

  initial begin
    rst = 1'b1; s_valid = '0; s_last = '0; s_data = '0; tx_full = 1'b0;
    hs = '0; hold = '0; full_cfg = 1'b0;
    #2;
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_wr_uart", 32'(wr_uart), 32'd0);
    checkOutput("rst_w_data", 32'(w_data), 32'd0);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
    @(negedge clk); #1 rst = 1'b0;

    $display("[TB] single request frame");
    src_push(0, 8'h11, 0); src_push(0, 8'h22, 0); src_push(0, 8'h33, 1);
    exp_begin(0); exp_byte(8'h11); exp_byte(8'h22); exp_byte(8'h33); exp_end();
    run_until(0, 30, "t1_drain", used);
    checkOutput("t1_cycles", 32'(used), 32'd7);

    @(negedge clk); #1 rst = 1'b1;
    #1 checkOutput("rst2_busy", 32'(busy), 32'd0);
    @(negedge clk); #1 rst = 1'b0;

    $display("[TB] four simultaneous requesters");
    for (int i = 0; i < NREQ; i++) src_push(i, 8'hA0 + 8'(i), 1);
    for (int i = 0; i < NREQ; i++) begin exp_begin(i); exp_byte(8'hA0 + 8'(i)); exp_end(); end
    run_until(0, 60, "t2_drain", used);
    src_push(2, 8'hB2, 1); src_push(0, 8'hB0, 1);
    exp_begin(0); exp_byte(8'hB0); exp_end();
    exp_begin(2); exp_byte(8'hB2); exp_end();
    run_until(0, 40, "t2b_drain", used);

    $display("[TB] tx_full stall in ID");
    src_push(0, 8'h5A, 1);
    exp_begin(0); exp_byte(8'h5A); exp_end();
    run_until(3, 20, "t3_sof", used);
    full_cfg = 1'b1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus();
      checkOutput("t3_wr_held", 32'(wr_uart), 32'd0);
      checkOutput("t3_w_data_held", 32'(w_data), 32'h00);
    end
    full_cfg = 1'b0;
    run_until(0, 20, "t3_drain", used);

    $display("[TB] MAX_LEN truncation");
    for (int i = 1; i <= 6; i++) src_push(1, 8'(i), i == 6);
    exp_begin(1); for (int i = 1; i <= 4; i++) exp_byte(8'(i)); exp_end();
    exp_begin(1); exp_byte(8'h05); exp_byte(8'h06); exp_end();
    run_until(0, 40, "t4_drain", used);
    checkOutput("t4_cycles", 32'(used), 32'd14);
    for (int i = 0; i < 4; i++) src_push(3, 8'h10 * 8'(i + 1), i == 3);
    exp_begin(3); for (int i = 0; i < 4; i++) exp_byte(8'h10 * 8'(i + 1)); exp_end();
    run_until(0, 30, "t4b_drain", used);

    $display("[TB] reset during payload");
    src_push(2, 8'h21, 0); src_push(2, 8'h22, 0); src_push(2, 8'h23, 1);
    exp_begin(2); exp_byte(8'h21);
    run_until(0, 20, "t5_partial", used);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    checkOutput("t5_wr_uart", 32'(wr_uart), 32'd0);
    checkOutput("t5_w_data", 32'(w_data), 32'd0);
    checkOutput("t5_grant", 32'(grant), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_s_ready", 32'(s_ready), 32'd0);
    void'(src_q[2].pop_front());
    hs = '0;
    src_push(1, 8'h31, 1); src_push(3, 8'h33, 1);
    exp_begin(1); exp_byte(8'h31); exp_end();
    exp_begin(2); exp_byte(8'h22); exp_byte(8'h23); exp_end();
    exp_begin(3); exp_byte(8'h33); exp_end();
    applyStimulus();
    rst = 1'b0;
    run_until(0, 60, "t5_drain", used);

    $display("[TB] granted source stalls mid-payload");
    src_push(0, 8'h61, 0); src_push(0, 8'h62, 0); src_push(0, 8'h63, 1);
    src_push(1, 8'h71, 1); src_push(2, 8'h72, 1);
    exp_begin(0); exp_byte(8'h61); exp_byte(8'h62); exp_byte(8'h63); exp_end();
    exp_begin(1); exp_byte(8'h71); exp_end();
    exp_begin(2); exp_byte(8'h72); exp_end();
    run_until(11, 20, "t6_first", used);
    hold = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      checkOutput("t6_wr_uart", 32'(wr_uart), 32'd0);
      checkOutput("t6_grant", 32'(grant), 32'b0001);
      checkOutput("t6_s_ready", 32'(s_ready), 32'd0);
    end
    hold = '0;
    run_until(0, 60, "t6_drain", used);

    applyStimulus();
    applyStimulus();
    checkOutput("end_busy", 32'(busy), 32'd0);
    checkOutput("end_grant", 32'(grant), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
